// File: rtl/tick_bcd_timer_pkg.sv
// Shared state encodings, BCD constants and digit helpers for the tick-driven
// two-digit BCD timer.
package tick_bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] DIGIT_ZERO = 4'd0;

  // Single-digit decimal increment; stays inside 0-9 with no wider intermediate.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d == DIGIT_MAX) ? DIGIT_ZERO : d + 4'd1;
  endfunction

endpackage

// File: rtl/tick_bcd_timer_digit.sv
// One BCD digit: synchronous clear, increment rolling 9 -> 0, carry out on
// the increment that rolls over.
module bcd_digit
  import tick_bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  logic [3:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr)      value_d = DIGIT_ZERO;
    else if (inc) value_d = bcd_inc(value_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= DIGIT_ZERO;
    else     value_q <= value_d;
  end

  assign value = value_q;
  assign carry = inc & (value_q == DIGIT_MAX);

endmodule

// File: rtl/tick_bcd_timer.sv
// Two-digit BCD event timer counting rising edges of an upstream carry under
// an IDLE/RUN/PAUSE/DONE state machine; wraps with cout or stops at the limit.
module tick_bcd_timer
  import tick_bcd_timer_pkg::*;
#(
  parameter logic [3:0] LIMIT_TENS = 4'd5,
  parameter logic [3:0] LIMIT_ONES = 4'd9,
  parameter bit         WRAP       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       running,
  output logic       done,
  output logic       cout
);

  logic       tick_q;
  logic       tick_ev;
  state_e     state_q, state_d;
  logic       running_q, running_d;
  logic       done_q, done_d;
  logic       cout_q, cout_d;

  logic [3:0] ones_v, tens_v;
  logic       ones_carry, tens_carry_unused;
  logic       count_ev, wrap_ev, dig_inc, dig_clr;
  logic       at_limit, next_at_limit;
  logic [3:0] ones_nx, tens_nx;

  assign tick_ev = tick & ~tick_q;

  // A tick only counts in RUN and never against a same-cycle clear.
  assign count_ev = (state_q == ST_RUN) & tick_ev & ~clr;

  assign ones_nx       = bcd_inc(ones_v);
  assign tens_nx       = (ones_v == DIGIT_MAX) ? bcd_inc(tens_v) : tens_v;
  assign at_limit      = (ones_v == LIMIT_ONES) && (tens_v == LIMIT_TENS);
  assign next_at_limit = (ones_nx == LIMIT_ONES) && (tens_nx == LIMIT_TENS);

  // Wrap reuses the digit clear path, so 59 -> 00 never passes through 60.
  assign wrap_ev = count_ev & at_limit & WRAP;
  assign dig_inc = count_ev & ~wrap_ev;
  assign dig_clr = clr | wrap_ev;

  bcd_digit u_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (dig_clr),
    .inc   (dig_inc),
    .value (ones_v),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst   (rst),
    .clr   (dig_clr),
    .inc   (ones_carry),
    .value (tens_v),
    .carry (tens_carry_unused)
  );

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN: begin
          // Landing on the limit without wrap ends the run, even with stop.
          if (count_ev && !WRAP && next_at_limit) state_d = ST_DONE;
          else if (stop)                          state_d = ST_PAUSE;
        end
        ST_PAUSE: if (start) state_d = ST_RUN;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    cout_d    = wrap_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= 1'b0;
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      tick_q    <= tick;
      state_q   <= state_d;
      running_q <= running_d;
      done_q    <= done_d;
      cout_q    <= cout_d;
    end
  end

  assign ones    = ones_v;
  assign tens    = tens_v;
  assign running = running_q;
  assign done    = done_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Directed bench: a wrapping 59 timer (w) and a stopping 05 timer (s).
module tb_tick_bcd_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_w = 0, start_w = 0, stop_w = 0, clr_w = 0;
  logic tick_s = 0, start_s = 0, stop_s = 0, clr_s = 0;
  logic [3:0] ones_w, tens_w, ones_s, tens_s;
  logic running_w, done_w, cout_w, running_s, done_s, cout_s;
  int tests = 0;
  int fails = 0;
  int cout_w_hits = 0;

  always #5 clk = ~clk;

  tick_bcd_timer #(.LIMIT_TENS(4'd5), .LIMIT_ONES(4'd9), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .tick(tick_w), .start(start_w), .stop(stop_w), .clr(clr_w),
    .ones(ones_w), .tens(tens_w), .running(running_w), .done(done_w), .cout(cout_w)
  );

  tick_bcd_timer #(.LIMIT_TENS(4'd0), .LIMIT_ONES(4'd5), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .tick(tick_s), .start(start_s), .stop(stop_s), .clr(clr_s),
    .ones(ones_s), .tens(tens_s), .running(running_s), .done(done_s), .cout(cout_s)
  );

  always @(posedge clk) cout_w_hits <= cout_w_hits + (cout_w ? 1 : 0);

  task automatic w_ticks(input int n, input int low);
    for (int i = 0; i < n; i++) begin
      tick_w = 1'b1; @(negedge clk);
      tick_w = 1'b0; repeat (low) @(negedge clk);
    end
  endtask

  task automatic s_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_s = 1'b1; @(negedge clk);
      tick_s = 1'b0; @(negedge clk);
    end
  endtask

  task automatic w_cmd(input logic s, input logic p, input logic c);
    start_w = s; stop_w = p; clr_w = c;
    @(negedge clk);
    start_w = 1'b0; stop_w = 1'b0; clr_w = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if ({tens_w, ones_w} !== 8'h00) begin fails++; $display("FAIL reset_count_w got %h exp 00", {tens_w, ones_w}); end
    tests++; if ({running_w, done_w, cout_w} !== 3'b000) begin fails++; $display("FAIL reset_flags_w got %b exp 000", {running_w, done_w, cout_w}); end
    tests++; if ({tens_s, ones_s, running_s, done_s, cout_s} !== 11'd0) begin fails++; $display("FAIL reset_s got %h exp 0", {tens_s, ones_s, running_s, done_s, cout_s}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_count12;
    int hits0;
    w_cmd(1'b1, 1'b0, 1'b0);
    hits0 = cout_w_hits;
    w_ticks(12, 15);
    @(negedge clk);
    tests++; if (tens_w !== 4'd1) begin fails++; $display("FAIL cnt12_tens got %0d exp 1", tens_w); end
    tests++; if (ones_w !== 4'd2) begin fails++; $display("FAIL cnt12_ones got %0d exp 2", ones_w); end
    tests++; if (running_w !== 1'b1) begin fails++; $display("FAIL cnt12_running got %b exp 1", running_w); end
    tests++; if (cout_w_hits != hits0) begin fails++; $display("FAIL cnt12_cout got %0d pulses exp 0", cout_w_hits - hits0); end
  endtask

  task automatic test_wrap;
    w_cmd(1'b0, 1'b0, 1'b1);
    w_cmd(1'b1, 1'b0, 1'b0);
    w_ticks(59, 1);
    tests++; if ({tens_w, ones_w, cout_w} !== {4'd5, 4'd9, 1'b0}) begin fails++; $display("FAIL wrap_pre got %h%h cout %b exp 59 cout 0", tens_w, ones_w, cout_w); end
    tick_w = 1'b1; @(negedge clk);
    tests++; if ({tens_w, ones_w} !== 8'h00) begin fails++; $display("FAIL wrap_count got %h%h exp 00", tens_w, ones_w); end
    tests++; if (cout_w !== 1'b1) begin fails++; $display("FAIL wrap_cout got %b exp 1", cout_w); end
    tick_w = 1'b0; @(negedge clk);
    tests++; if ({cout_w, running_w} !== 2'b01) begin fails++; $display("FAIL wrap_after got cout %b run %b exp 0 1", cout_w, running_w); end
    w_ticks(59, 1);
    tick_w = 1'b1; stop_w = 1'b1; @(negedge clk);
    tick_w = 1'b0; stop_w = 1'b0;
    tests++; if ({tens_w, ones_w, cout_w, running_w} !== {8'h00, 1'b1, 1'b0}) begin fails++; $display("FAIL wrap_stop got %h%h cout %b run %b exp 00 1 0", tens_w, ones_w, cout_w, running_w); end
    @(negedge clk);
    tests++; if (cout_w !== 1'b0) begin fails++; $display("FAIL wrap_stop_cout got %b exp 0", cout_w); end
  endtask

  task automatic test_stop_limit;
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    s_ticks(5);
    tests++; if ({tens_s, ones_s} !== 8'h05) begin fails++; $display("FAIL lim_count got %h%h exp 05", tens_s, ones_s); end
    tests++; if ({done_s, running_s, cout_s} !== 3'b100) begin fails++; $display("FAIL lim_flags got %b exp 100", {done_s, running_s, cout_s}); end
    s_ticks(2);
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    s_ticks(1);
    tests++; if ({tens_s, ones_s, done_s} !== {8'h05, 1'b1}) begin fails++; $display("FAIL lim_hold got %h%h done %b exp 05 1", tens_s, ones_s, done_s); end
    clr_s = 1'b1; @(negedge clk); clr_s = 1'b0;
    tests++; if ({tens_s, ones_s, done_s, running_s} !== 10'd0) begin fails++; $display("FAIL lim_clr got %h%h done %b run %b exp 00 0 0", tens_s, ones_s, done_s, running_s); end
  endtask

  task automatic test_hold_and_simul;
    w_cmd(1'b0, 1'b0, 1'b1);
    w_cmd(1'b1, 1'b0, 1'b0);
    tick_w = 1'b1; repeat (10) @(negedge clk);
    tick_w = 1'b0; @(negedge clk);
    tests++; if ({tens_w, ones_w} !== 8'h01) begin fails++; $display("FAIL held_tick got %h%h exp 01", tens_w, ones_w); end
    tick_w = 1'b1; stop_w = 1'b1; @(negedge clk);
    tick_w = 1'b0; stop_w = 1'b0;
    tests++; if ({tens_w, ones_w, running_w} !== {8'h02, 1'b0}) begin fails++; $display("FAIL tick_stop got %h%h run %b exp 02 0", tens_w, ones_w, running_w); end
    @(negedge clk);
    tick_w = 1'b1; start_w = 1'b1; @(negedge clk);
    tick_w = 1'b0; start_w = 1'b0;
    tests++; if ({tens_w, ones_w, running_w} !== {8'h02, 1'b1}) begin fails++; $display("FAIL tick_start got %h%h run %b exp 02 1", tens_w, ones_w, running_w); end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    w_cmd(1'b0, 1'b0, 1'b1);
    w_cmd(1'b1, 1'b0, 1'b0);
    w_ticks(37, 1);
    tests++; if ({tens_w, ones_w, running_w} !== {8'h37, 1'b1}) begin fails++; $display("FAIL pre_rst got %h%h run %b exp 37 1", tens_w, ones_w, running_w); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({tens_w, ones_w, running_w} !== 9'd0) begin fails++; $display("FAIL async_rst got %h%h run %b exp 00 0", tens_w, ones_w, running_w); end
    @(negedge clk); rst = 1'b0;
    w_ticks(3, 1);
    tests++; if ({tens_w, ones_w, running_w} !== 9'd0) begin fails++; $display("FAIL post_rst_idle got %h%h run %b exp 00 0", tens_w, ones_w, running_w); end
  endtask

  task automatic test_clr_priority;
    w_cmd(1'b1, 1'b0, 1'b0);
    w_ticks(9, 1);
    tests++; if ({tens_w, ones_w} !== 8'h09) begin fails++; $display("FAIL pre_clr got %h%h exp 09", tens_w, ones_w); end
    tick_w = 1'b1; start_w = 1'b1; clr_w = 1'b1; @(negedge clk);
    tick_w = 1'b0; start_w = 1'b0; clr_w = 1'b0;
    tests++; if ({tens_w, ones_w, running_w, done_w} !== 10'd0) begin fails++; $display("FAIL clr_prio got %h%h run %b done %b exp 00 0 0", tens_w, ones_w, running_w, done_w); end
  endtask

  initial begin
    test_reset();
    test_count12();
    test_wrap();
    test_stop_limit();
    test_hold_and_simul();
    test_async_reset();
    test_clr_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tick_bcd_timer.md
# tick_bcd_timer

Two-digit BCD event timer that sits directly downstream of the 4-bit free-running counter and consumes its carry output as a tick. It counts carry events into ones/tens decimal digits under a start/stop/clear state machine. It stops at a programmable limit or wraps and emits its own carry pulse so instances cascade (seconds → minutes).

## Interface
Parameters:
- LIMIT_TENS, default 5: tens digit of the terminal value, range 0–9.
- LIMIT_ONES, default 9: ones digit of the terminal value, range 0–9. The terminal value LIMIT_TENS:LIMIT_ONES must not be 00.
- WRAP, default 1:
  - 1: roll over to 00 at the limit and pulse `cout`.
  - 0: stop at the limit in DONE.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  carry from the upstream 4-bit counter; only its rising edge counts.
- start  in  1  one-cycle command: begin or resume counting.
- stop  in  1  one-cycle command: pause counting.
- clr  in  1  one-cycle synchronous clear to 00 / IDLE.
- ones  out  4  BCD ones digit, registered.
- tens  out  4  BCD tens digit, registered.
- running  out  1  high while state is RUN, registered.
- done  out  1  high while state is DONE, registered.
- cout  out  1  one-cycle pulse on wrap from limit to 00 (WRAP=1 only), registered.

## Operation
- Tick event = tick & ~tick_d, where tick_d is tick registered.
  - A tick held high for several cycles counts once.
  - After reset, tick_d = 0, so a tick already high when reset releases counts once, but only if the state is RUN.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority: clr > stop > start, evaluated every cycle.
- clr in any state → IDLE; ones = tens = 0; cout = 0.
- IDLE:
  - start → RUN.
  - Count stays 00.
  - Tick events are ignored.
- RUN:
  - Each tick event increments the count.
  - ones 9 → 0 with tens + 1; otherwise ones + 1.
  - stop → PAUSE.
  - start is ignored.
- PAUSE:
  - Count is held.
  - start → RUN.
  - stop is ignored.
- Limit handling in RUN (tick event while count == LIMIT_TENS:LIMIT_ONES):
  - WRAP=1: count → 00, cout = 1 for one cycle, stay in RUN.
  - WRAP=0: not reachable. A tick event that moves the count onto the limit also moves the state to DONE on the same edge.
- DONE:
  - Count is held at the limit.
  - start, stop and tick are ignored; only clr exits.
- Simultaneous events:
  - Tick event + stop while in RUN: the tick is counted and the state becomes PAUSE.
  - Tick event + start while in PAUSE or IDLE: the tick is not counted and the state becomes RUN.
  - Tick event + clr: clr wins, count = 00.
  - Limit wrap + stop: count → 00, cout pulses, state becomes PAUSE.
- Digits never leave the range 0–9; no binary intermediate wider than 4 bits per digit.
- Outputs derived from state:
  - running = (state == RUN).
  - done = (state == DONE).
  - cout = 0 on every cycle that is not a wrap.

## Timing
- Reset values: ones = 0, tens = 0, running = 0, done = 0, cout = 0, tick_d = 0, state = IDLE. Reset takes effect immediately and asynchronously.
- Reset mid-count: all outputs clear immediately. After release, the block sits in IDLE until start.
- Tick latency:
  - tick sampled high (previous sample low) at edge N → the new count is visible after edge N.
  - running/done/cout update on the same edge.
- Command latency: start/stop/clr sampled at edge N → state and outputs change after edge N.
- cout is high for exactly one clock.
- Minimum tick spacing is two clocks: high for one sample, low for one sample. The upstream 4-bit counter delivers one tick every 16 clocks.

## Structure
- Shared package/header holds:
  - State encodings: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - BCD constants: DIGIT_MAX = 4'd9, DIGIT_ZERO = 4'd0.
- Sub-module bcd_digit, instantiated twice (ones, tens):
  - Inputs: clk, rst, clr, inc.
  - Outputs: 4-bit value, carry = inc & (value == 9).
  - Each digit rolls 9 → 0.
- Top level holds the FSM, tick edge detect, limit compare and cout register.

## Test plan
- Reset, then start, then 12 tick pulses spaced 16 clocks apart → tens = 1, ones = 2, running = 1, cout never high.
- WRAP=1, limit 59: run 60 ticks → after the 60th tick, count = 00, cout = 1 for exactly one clock, running stays 1.
- WRAP=0, limit 05: run 7 ticks → after the 5th tick, count = 05 and done = 1; ticks 6–7 and a start leave count 05; clr → 00, done = 0, running = 0.
- Tick held high 10 clocks in RUN → count advances by exactly 1; tick + stop on the same edge → count advances, running = 0; tick + start in PAUSE → count unchanged, running = 1.
- From count 37 in RUN, assert rst mid-cycle → ones = tens = 0 and running = 0 before the next clock edge; ticks after release with no start → count stays 00.
- clr + start + tick on the same edge from RUN at count 09 → count = 00, state IDLE (running = 0, done = 0).
